// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin arbiter sharing the async FIFO write port
module fifo_wr_arbiter #(
    parameter int NREQ      = 4,
    parameter int DSIZE     = 8,
    parameter int BURST_MAX = 4
) (
    input  logic                             wclk,
    input  logic                             wrst_n,
    input  logic [NREQ-1:0]                  req_valid,
    input  logic [NREQ-1:0]                  req_last,
    input  logic [NREQ*DSIZE-1:0]            req_data,
    output logic [NREQ-1:0]                  req_ready,
    input  logic                             wfull,
    output logic                             winc,
    output logic [DSIZE-1:0]                 wdata,
    output logic                             gnt_valid,
    output logic [$clog2(NREQ)-1:0]          gnt_id,
    output logic [$clog2(BURST_MAX+1)-1:0]   beat_cnt
);
    localparam int IW = $clog2(NREQ);
    localparam int CW = $clog2(BURST_MAX + 1);
    localparam logic [CW-1:0] BMAX     = CW'(BURST_MAX);
    localparam logic [IW-1:0] LAST_IDX = IW'(NREQ - 1);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t        state, state_nxt;
    logic [IW-1:0] owner, owner_nxt;
    logic [IW-1:0] rr_ptr, rr_ptr_nxt;
    logic [IW-1:0] sel, cand;
    logic [CW-1:0] beat_nxt;
    logic          sel_found;
    logic          own_valid;
    logic          xfer;
    logic          release_now;

    // Search starts one past the last owner so the last owner has lowest priority.
    always_comb begin
        sel       = '0;
        cand      = '0;
        sel_found = 1'b0;
        for (int i = 1; i <= NREQ; i++) begin
            cand = IW'((int'(rr_ptr) + i) % NREQ);
            if (!sel_found && req_valid[cand]) begin
                sel_found = 1'b1;
                sel       = cand;
            end
        end
    end

    always_comb begin
        state_nxt   = state;
        owner_nxt   = owner;
        rr_ptr_nxt  = rr_ptr;
        beat_nxt    = beat_cnt;
        own_valid   = req_valid[owner];
        xfer        = 1'b0;
        release_now = 1'b0;
        winc        = 1'b0;
        req_ready   = '0;
        wdata       = req_data[int'(owner)*DSIZE +: DSIZE];
        case (state)
            IDLE: begin
                if (sel_found) begin
                    owner_nxt = sel;
                    beat_nxt  = '0;
                    state_nxt = GRANT;
                end
            end
            GRANT: begin
                xfer             = own_valid & ~wfull;
                winc             = xfer;
                req_ready[owner] = ~wfull;
                if (xfer) begin
                    beat_nxt = beat_cnt + CW'(1);
                end
                // Last word and burst limit on the same beat collapse into one release.
                release_now = ~own_valid
                            | (xfer & (req_last[owner] | (beat_cnt + CW'(1) == BMAX)));
                if (release_now) begin
                    state_nxt  = IDLE;
                    rr_ptr_nxt = owner;
                end
            end
        endcase
    end

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            state    <= IDLE;
            owner    <= '0;
            rr_ptr   <= LAST_IDX;
            beat_cnt <= '0;
        end else begin
            state    <= state_nxt;
            owner    <= owner_nxt;
            rr_ptr   <= rr_ptr_nxt;
            beat_cnt <= beat_nxt;
        end
    end

    assign gnt_valid = (state == GRANT);
    assign gnt_id    = owner;

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
Round-robin arbiter that shares the single write port of the asynchronous FIFO among NREQ requesters in the write clock domain. It grants one requester at a time for a burst, muxes that requester's data onto wdata, and drives winc gated by wfull so no word is ever presented while the FIFO is full. The block sits directly in front of the FIFO write side (winc/wdata/wfull) and runs entirely on wclk.

Parameters:
NREQ, 4, number of requesters (2..8)
DSIZE, 8, data word width; must match the FIFO DSIZE
BURST_MAX, 4, maximum words transferred per grant before forced release (1..255)

Ports:
wclk  in  1  write-domain clock
wrst_n  in  1  asynchronous active-low reset
req_valid  in  NREQ  per-requester word valid
req_last  in  NREQ  per-requester last word of burst, qualified by req_valid
req_data  in  NREQ*DSIZE  packed data; requester i occupies bits [i*DSIZE +: DSIZE]
req_ready  out  NREQ  per-requester accept; one-hot or zero
wfull  in  1  FIFO full flag (registered in the FIFO, wclk domain)
winc  out  1  FIFO write enable
wdata  out  DSIZE  FIFO write data
gnt_valid  out  1  high while a grant is held (state GRANT)
gnt_id  out  $clog2(NREQ)  index of current owner; holds last owner when gnt_valid=0
beat_cnt  out  $clog2(BURST_MAX+1)  words transferred in current grant

Behaviour:
- Clock and reset: one clock, wclk; wrst_n is asynchronous, active low. Reset values: state=IDLE, owner=0, rr_ptr=NREQ-1 (requester 0 has highest priority after reset), beat_cnt=0, gnt_valid=0, gnt_id=0. winc=0 and req_ready=0 combinationally whenever state=IDLE, including immediately on reset assertion.
- Transfer: in GRANT, xfer = req_valid[owner] & ~wfull.
- Combinational outputs in GRANT:
  - winc = xfer.
  - wdata = req_data[owner].
  - req_ready[owner] = ~wfull; all other req_ready bits = 0.
- Combinational outputs in IDLE:
  - wdata = req_data[owner].
  - winc = 0.
  - req_ready = 0.
- Zero-latency path: data and winc pass combinationally to the FIFO in the same cycle. The FIFO's full computation already includes winc, so wfull rises on the edge after the last free slot is written.
- State machine, IDLE:
  - If no req_valid bit is set, stay in IDLE.
  - Otherwise select the first set bit searching rr_ptr+1, rr_ptr+2, ... modulo NREQ.
  - Register the selection as owner, clear beat_cnt, and go to GRANT.
  - The arbitration cycle transfers no data, so there is exactly one idle cycle between grants.
- State machine, GRANT:
  - On xfer, beat_cnt increments.
  - Go to IDLE and load rr_ptr=owner when any of the following holds:
    - xfer & req_last[owner];
    - xfer & (beat_cnt+1 == BURST_MAX);
    - ~req_valid[owner] (owner abandoned the burst).
  - wfull high with req_valid[owner] high: hold GRANT; no beat is counted and data is held by the requester.
- Simultaneous events:
  - req_last coinciding with BURST_MAX produces a single release.
  - On release, beat_cnt shows the final count for that cycle and clears on entry to the next GRANT.
- Handshake rules: req_valid must stay high once raised until accepted. req_data and req_last must stay stable while valid & ~ready. Requests from non-owners are ignored during GRANT.
- Reset mid-burst: the partial burst is abandoned and no further writes are issued. Requesters must re-request after reset.

Test Plan:
1. Reset, then all four req_valid=1 with req_last=1 on every word, wfull=0 -> grants in order 0,1,2,3,0; one winc per grant; winc pattern 0,1,0,1...
2. Only requester 2 valid, 6 words, req_last on word 6, BURST_MAX=4 -> 4 consecutive winc with beat_cnt 0..3, one IDLE cycle, regrant to 2, 2 winc, release; wdata sequence matches the input words.
3. Requester 1 granted, wfull=1 for 5 cycles mid-burst -> winc=0, req_ready[1]=0, beat_cnt frozen, gnt_id=1 held; after wfull=0, the same word is written on the first cycle.
4. Requesters 0 and 3 valid, 0 asserts req_last on its 2nd word -> release after beat_cnt=2, next grant is 3 (not 0).
5. Owner 1 drops req_valid after 1 word -> IDLE next cycle, rr_ptr=1; pending requester 2 is granted next.
6. wrst_n pulsed low mid-burst (async, between clock edges) -> winc and req_ready go 0 immediately; after release, gnt_valid=0 and the first grant goes to the lowest-indexed valid requester.
